// File: rtl/pc_ctrl_if.sv
// Bus between pc_ctrl and the program memory / register file / input handshake.
// master drives instruction fields and sw_ready; slave (pc_ctrl) returns PC and status.
interface pc_ctrl_if #(
    parameter int unsigned Psize = 6,
    parameter int unsigned Osize = 3
);
    logic [Osize-1:0] opcode;
    logic [Psize-1:0] imm;
    logic             zero;
    logic             sw_ready;
    logic [Psize-1:0] PCout;
    logic             regWE;
    logic             waiting;
    logic             halted;

    modport master (
        output opcode,
        output imm,
        output zero,
        output sw_ready,
        input  PCout,
        input  regWE,
        input  waiting,
        input  halted
    );

    modport slave (
        input  opcode,
        input  imm,
        input  zero,
        input  sw_ready,
        output PCout,
        output regWE,
        output waiting,
        output halted
    );
endinterface

// File: rtl/pc_ctrl.sv
// picoMIPS program-flow controller: PC register, branch/jump, input-wait and halt FSM.
// Optional single-entry CALL/RET link register enabled by defining PC_CALL_RET_EN.
module pc_ctrl #(
    parameter int unsigned Psize = 6,
    parameter int unsigned Osize = 3
) (
    input logic      clk,
    input logic      reset,
    pc_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StRun, StWaitHi, StWaitLo, StHalt} state_e;

    localparam logic [Osize-1:0] OpBeq  = Osize'(1);
    localparam logic [Osize-1:0] OpBne  = Osize'(2);
    localparam logic [Osize-1:0] OpJmp  = Osize'(3);
    localparam logic [Osize-1:0] OpWait = Osize'(4);
    localparam logic [Osize-1:0] OpHalt = Osize'(5);
`ifdef PC_CALL_RET_EN
    localparam logic [Osize-1:0] OpCall = Osize'(6);
    localparam logic [Osize-1:0] OpRet  = Osize'(7);
`endif

    state_e           state_q, state_d;
    logic [Psize-1:0] pc_q, pc_d;
    logic [Psize-1:0] pc_inc;
    logic             waiting_q, waiting_d;
    logic             halted_q, halted_d;
    logic             reg_we;
`ifdef PC_CALL_RET_EN
    logic [Psize-1:0] link_q, link_d;
`endif

    // Natural truncation gives the modulo-2^Psize wrap.
    assign pc_inc = pc_q + Psize'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        reg_we  = 1'b0;
`ifdef PC_CALL_RET_EN
        link_d  = link_q;
`endif
        unique case (state_q)
            StRun: begin
                case (bus.opcode)
                    OpBeq:  pc_d = bus.zero ? bus.imm : pc_inc;
                    OpBne:  pc_d = bus.zero ? pc_inc : bus.imm;
                    OpJmp:  pc_d = bus.imm;
                    OpWait: state_d = StWaitHi;
                    OpHalt: state_d = StHalt;
`ifdef PC_CALL_RET_EN
                    OpCall: begin
                        link_d = pc_inc;
                        pc_d   = bus.imm;
                    end
                    OpRet:  pc_d = link_q;
`endif
                    // ALU, plus CALL/RET when the link register is compiled out.
                    default: begin
                        reg_we = 1'b1;
                        pc_d   = pc_inc;
                    end
                endcase
            end
            StWaitHi: begin
                if (bus.sw_ready) state_d = StWaitLo;
            end
            StWaitLo: begin
                if (!bus.sw_ready) begin
                    state_d = StRun;
                    pc_d    = pc_inc;
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StRun;
        endcase
    end

    assign waiting_d = (state_d == StWaitHi) || (state_d == StWaitLo);
    assign halted_d  = (state_d == StHalt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StRun;
            pc_q      <= '0;
            waiting_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            waiting_q <= waiting_d;
            halted_q  <= halted_d;
        end
    end

`ifdef PC_CALL_RET_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            link_q <= '0;
        end else begin
            link_q <= link_d;
        end
    end
`endif

    assign bus.PCout   = pc_q;
    assign bus.regWE   = reg_we;
    assign bus.waiting = waiting_q;
    assign bus.halted  = halted_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl (default Psize=6, Osize=3).
// Follows the PC_CALL_RET_EN build choice for the CALL/RET section.
module tb_pc_ctrl;

    localparam logic [2:0] OpAlu  = 3'd0;
    localparam logic [2:0] OpBeq  = 3'd1;
    localparam logic [2:0] OpBne  = 3'd2;
    localparam logic [2:0] OpJmp  = 3'd3;
    localparam logic [2:0] OpWait = 3'd4;
    localparam logic [2:0] OpHalt = 3'd5;
    localparam logic [2:0] OpCall = 3'd6;
    localparam logic [2:0] OpRet  = 3'd7;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pc_ctrl_if #(.Psize(6), .Osize(3)) bus ();

    pc_ctrl #(
        .Psize(6),
        .Osize(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [5:0] im, input logic z);
        bus.opcode = op;
        bus.imm    = im;
        bus.zero   = z;
        #1;
    endtask

    task automatic jump_to(input logic [5:0] target);
        set_instr(OpJmp, target, 1'b0);
        tick();
        check("jmp_target", 32'(bus.PCout), 32'(target));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.opcode   = OpAlu;
        bus.imm      = '0;
        bus.zero     = 1'b0;
        bus.sw_ready = 1'b0;

        // Reset state and ALU sequence
        tick();
        tick();
        check("rst_pc", 32'(bus.PCout), 0);
        check("rst_waiting", 32'(bus.waiting), 0);
        check("rst_halted", 32'(bus.halted), 0);
        reset = 1'b0;
        #1;
        check("alu_regwe0", 32'(bus.regWE), 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("alu_pc", 32'(bus.PCout), 32'(i));
            check("alu_regwe", 32'(bus.regWE), 1);
        end
        tick();
        tick();
        check("alu_pc5", 32'(bus.PCout), 5);
        // Asynchronous reset, well away from any clock edge
        reset = 1'b1;
        #1;
        check("async_rst_pc", 32'(bus.PCout), 0);
        reset = 1'b0;
        #1;

        // Branches
        set_instr(OpBeq, 6'd20, 1'b1);
        check("beq_regwe", 32'(bus.regWE), 0);
        tick();
        check("beq_taken", 32'(bus.PCout), 20);
        jump_to(6'd7);
        set_instr(OpBeq, 6'd20, 1'b0);
        check("beq_nt_regwe", 32'(bus.regWE), 0);
        tick();
        check("beq_not_taken", 32'(bus.PCout), 8);
        set_instr(OpBne, 6'd9, 1'b0);
        check("bne_regwe", 32'(bus.regWE), 0);
        tick();
        check("bne_taken", 32'(bus.PCout), 9);
        set_instr(OpBne, 6'd30, 1'b1);
        tick();
        check("bne_not_taken", 32'(bus.PCout), 10);
        set_instr(OpJmp, 6'd10, 1'b0);
        check("jmp_regwe", 32'(bus.regWE), 0);
        tick();
        tick();
        check("self_loop_pc", 32'(bus.PCout), 10);
        check("self_loop_halted", 32'(bus.halted), 0);

        // PC wrap
        jump_to(6'd63);
        set_instr(OpAlu, 6'd0, 1'b0);
        tick();
        check("wrap_pc", 32'(bus.PCout), 0);

        // WAIT: low 5 cycles, high 2, then release
        jump_to(6'd4);
        set_instr(OpWait, 6'd33, 1'b0);
        check("wait_regwe_run", 32'(bus.regWE), 0);
        tick();
        // ALU on the bus during the wait must not write or advance
        set_instr(OpAlu, 6'd50, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("wait_hi_waiting", 32'(bus.waiting), 1);
            check("wait_hi_pc", 32'(bus.PCout), 4);
            check("wait_hi_regwe", 32'(bus.regWE), 0);
            tick();
        end
        bus.sw_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("wait_lo_waiting", 32'(bus.waiting), 1);
            check("wait_lo_pc", 32'(bus.PCout), 4);
            check("wait_lo_regwe", 32'(bus.regWE), 0);
        end
        bus.sw_ready = 1'b0;
        tick();
        check("wait_exit_pc", 32'(bus.PCout), 5);
        check("wait_exit_waiting", 32'(bus.waiting), 0);

        // WAIT with sw_ready already high, then reset in WAIT_LO
        jump_to(6'd4);
        bus.sw_ready = 1'b1;
        set_instr(OpWait, 6'd0, 1'b0);
        tick();
        set_instr(OpAlu, 6'd0, 1'b0);
        tick();
        check("wait2_waiting", 32'(bus.waiting), 1);
        check("wait2_pc", 32'(bus.PCout), 4);
        pulse_reset();
        check("wait_rst_pc", 32'(bus.PCout), 0);
        check("wait_rst_waiting", 32'(bus.waiting), 0);
        // sw_ready still high: only RUN would advance the PC here
        tick();
        check("wait_rst_run_pc", 32'(bus.PCout), 1);
        check("wait_rst_run_waiting", 32'(bus.waiting), 0);
        bus.sw_ready = 1'b0;

        // HALT holds against any opcode and sw_ready
        jump_to(6'd10);
        set_instr(OpHalt, 6'd0, 1'b0);
        tick();
        check("halt_halted", 32'(bus.halted), 1);
        check("halt_waiting", 32'(bus.waiting), 0);
        for (int i = 0; i < 20; i++) begin
            bus.sw_ready = i[0];
            set_instr(i[2:0], 6'(i * 3 + 1), i[1]);
            check("halt_regwe", 32'(bus.regWE), 0);
            tick();
            check("halt_pc", 32'(bus.PCout), 10);
            check("halt_hold", 32'(bus.halted), 1);
        end
        bus.sw_ready = 1'b0;
        pulse_reset();
        check("halt_rst_halted", 32'(bus.halted), 0);
        check("halt_rst_pc", 32'(bus.PCout), 0);

        // CALL / RET
        jump_to(6'd12);
        set_instr(OpCall, 6'd30, 1'b0);
`ifdef PC_CALL_RET_EN
        check("call_regwe", 32'(bus.regWE), 0);
        tick();
        check("call_pc", 32'(bus.PCout), 30);
        set_instr(OpRet, 6'd50, 1'b0);
        check("ret_regwe", 32'(bus.regWE), 0);
        tick();
        check("ret_pc", 32'(bus.PCout), 13);
        set_instr(OpCall, 6'd40, 1'b0);
        tick();
        set_instr(OpCall, 6'd50, 1'b0);
        tick();
        check("nested_call_pc", 32'(bus.PCout), 50);
        set_instr(OpRet, 6'd0, 1'b0);
        tick();
        check("nested_ret_pc", 32'(bus.PCout), 41);
`else
        check("call_regwe", 32'(bus.regWE), 1);
        tick();
        check("call_pc", 32'(bus.PCout), 13);
        set_instr(OpRet, 6'd50, 1'b0);
        check("ret_regwe", 32'(bus.regWE), 1);
        tick();
        check("ret_pc", 32'(bus.PCout), 14);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
